adder_4bit_seq_ctrl: RTL

// - Sequencer that runs multi-word addition through the existing combinational 4-bit adder (sum/c_out/A_data/B_data/c_in).
// - Takes two NIBBLES*4-bit operands, adds one nibble pair per clock (LSB first) and chains the carry between nibbles.
// - Returns the full sum plus final carry with a start/busy/done handshake.
// - Sits between a requesting controller/bench and a single shared 4-bit adder instance.

---
 rtl/adder_4bit_seq_ctrl_if.sv | 26 ++
 rtl/adder_4bit_seq_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/adder_4bit_seq_ctrl_if.sv
// Request-side bundle for the multi-word add sequencer: operands and start go in,
// while busy, done and the held sum come back.
interface adder_4bit_seq_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin_init;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out_final;

  modport master (
    output start, op_a, op_b, cin_init,
    input  busy, done, result, c_out_final
  );

  modport slave (
    input  start, op_a, op_b, cin_init,
    output busy, done, result, c_out_final
  );
endinterface

// File: rtl/adder_4bit_seq_ctrl.sv
// Runs a NIBBLES*4-bit addition through one shared combinational 4-bit adder,
// LSB nibble first, carrying between nibbles; start/busy/done handshake.
module adder_4bit_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_4bit_seq_ctrl_if.slave  req,
  output logic [3:0]            A_data,
  output logic [3:0]            B_data,
  output logic                  c_in,
  input  logic [3:0]            sum,
  input  logic                  c_out
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [W-1:0]   a_lat_q, b_lat_q;
  logic [W-1:0]   result_q, result_d;
  logic           carry_q;
  logic           c_out_final_q;

  logic           accept;
  logic           last_nib;
  logic [W-1:0]   a_sh, b_sh, nib_mask;

  // start is only honoured outside RUN, so a mid-run request cannot disturb the operation.
  assign accept   = req.start && (state_q != StRun);
  assign last_nib = (idx_q == IdxW'(NIBBLES - 1));

  assign a_sh     = a_lat_q >> (4 * idx_q);
  assign b_sh     = b_lat_q >> (4 * idx_q);
  assign nib_mask = W'(4'hF) << (4 * idx_q);
  assign result_d = (result_q & ~nib_mask) | (W'(sum) << (4 * idx_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req.start) state_d = StRun;
      StRun:   if (last_nib) state_d = StDone;
      StDone:  state_d = req.start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req.busy = 1'b0;
    req.done = 1'b0;
    A_data   = 4'h0;
    B_data   = 4'h0;
    c_in     = 1'b0;
    unique case (state_q)
      StRun: begin
        req.busy = 1'b1;
        A_data   = a_sh[3:0];
        B_data   = b_sh[3:0];
        c_in     = carry_q;
      end
      StDone:  req.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      a_lat_q       <= '0;
      b_lat_q       <= '0;
      result_q      <= '0;
      carry_q       <= 1'b0;
      c_out_final_q <= 1'b0;
    end else if (accept) begin
      idx_q         <= '0;
      a_lat_q       <= req.op_a;
      b_lat_q       <= req.op_b;
      result_q      <= '0;
      carry_q       <= req.cin_init;
      c_out_final_q <= 1'b0;
    end else if (state_q == StRun) begin
      result_q <= result_d;
      carry_q  <= c_out;
      idx_q    <= idx_q + 1'b1;
      if (last_nib) begin
        c_out_final_q <= c_out;
      end
    end
  end

  assign req.result      = result_q;
  assign req.c_out_final = c_out_final_q;

endmodule
